// File: rtl/can_shift_reg_if.sv
// Signal bundle for the CAN field shift register: control/data toward the
// register (master drives) and register state back (slave drives).
interface can_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             enable;
    logic             load;
    logic             clear;
    logic             serial_in;
    logic [WIDTH-1:0] par_in;
    logic [CW-1:0]    len;
    logic [WIDTH-1:0] par_out;
    logic             serial_out;
    logic [CW-1:0]    bit_cnt;
    logic             full;
    logic             done;

    modport master (
        output enable, load, clear, serial_in, par_in, len,
        input  par_out, serial_out, bit_cnt, full, done
    );

    modport slave (
        input  enable, load, clear, serial_in, par_in, len,
        output par_out, serial_out, bit_cnt, full, done
    );
endinterface

// File: rtl/can_shift_reg.sv
// WIDTH-bit serial/parallel shift register with bit counter for assembling
// and serialising CAN fields; flags full/done once len bits have been shifted.
module can_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CW        = $clog2(WIDTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    can_shift_reg_if.slave bus
);

    // len of 0 or beyond the register width means a full-width field
    function automatic logic [CW-1:0] eff_len_f(input logic [CW-1:0] l);
        if (l == '0 || l > CW'(WIDTH))
            return CW'(WIDTH);
        return l;
    endfunction

    function automatic logic [CW-1:0] sat_inc_f(input logic [CW-1:0] c);
        if (c == CW'(WIDTH))
            return c;
        return c + CW'(1);
    endfunction

    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    eff_len;

    assign eff_len = eff_len_f(bus.len);

    always_comb begin
        if (LSB_FIRST)
            shifted = {bus.serial_in, reg_q[WIDTH-1:1]};
        else
            shifted = {reg_q[WIDTH-2:0], bus.serial_in};
    end

    always_comb begin
        reg_d  = reg_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (bus.clear) begin
            reg_d = '0;
            cnt_d = '0;
        end else if (bus.load) begin
            reg_d = bus.par_in;
            cnt_d = '0;
        end else if (bus.enable) begin
            reg_d  = shifted;
            cnt_d  = sat_inc_f(cnt_q);
            // Only the shift that lands exactly on eff_len pulses; a saturated
            // counter or a len shrunk below bit_cnt never does.
            done_d = (cnt_q != CW'(WIDTH)) && (cnt_d == eff_len);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            reg_q  <= reg_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.par_out    = reg_q;
    assign bus.serial_out = LSB_FIRST ? reg_q[0] : reg_q[WIDTH-1];
    assign bus.bit_cnt    = cnt_q;
    assign bus.full       = (cnt_q >= eff_len);
    assign bus.done       = done_q;

endmodule

// File: doc/can_shift_reg.md
Name: can_shift_reg

Overview:
- Parametrised multi-bit successor to the single-bit shift cell.
- Provides a WIDTH-bit serial/parallel shift register with selectable shift direction, parallel load, synchronous clear, and a bit counter.
- The counter flags when a programmed number of bits (`len`) has been shifted.
- Used in the CAN bit-stream path for assembling received fields (ID, DLC, data bytes, CRC) and for serialising fields to transmit.

Parameters:
- WIDTH, 8: register width in bits; legal range 2..64.
- LSB_FIRST, 0: 0 = shift toward MSB, serial_in enters bit 0, serial_out = bit WIDTH-1; 1 = shift toward LSB, serial_in enters bit WIDTH-1, serial_out = bit 0.
- CW, $clog2(WIDTH+1): derived counter width; do not override.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- enable  in  1  shift one position this cycle
- load  in  1  parallel load from par_in
- clear  in  1  synchronous clear of register and counter
- serial_in  in  1  bit shifted in
- par_in  in  WIDTH  parallel load value
- len  in  CW  bits per field; 0 or >WIDTH means WIDTH
- par_out  out  WIDTH  register contents
- serial_out  out  1  bit at the shift-out end
- bit_cnt  out  CW  bits shifted since last load/clear/reset
- full  out  1  level: bit_cnt >= effective len
- done  out  1  one-cycle pulse when bit_cnt reaches effective len

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clock; reset is synchronous and active-high.
  - On reset: par_out = 0, bit_cnt = 0, full = 0, done = 0.
  - serial_out follows the register, so it is 0 after reset.
- Priority per cycle: reset > clear > load > enable. Lower-priority requests in the same cycle are ignored.
- clear: register = 0, bit_cnt = 0, done = 0.
- load:
  - register = par_in, bit_cnt = 0, done = 0.
  - serial_out shows the first bit to transmit in the following cycle.
- enable (no load/clear):
  - LSB_FIRST = 0: register = {register[WIDTH-2:0], serial_in}.
  - LSB_FIRST = 1: register = {serial_in, register[WIDTH-1:1]}.
  - bit_cnt increments and saturates at WIDTH; it never wraps.
- Idle: enable = 0 and no load/clear holds all state; done = 0.
- Effective length: eff_len = WIDTH if len == 0 or len > WIDTH, else len. len is sampled every cycle and is not latched.
- full: combinational compare, bit_cnt >= eff_len. It stays high while saturated, until load/clear/reset.
- done:
  - Registered pulse; high in the cycle after the shift edge where bit_cnt transitions from eff_len-1 to eff_len.
  - Exactly one pulse per field.
  - Further shifts with full already high produce no done pulse.
  - If len is changed mid-field to a value <= the current bit_cnt, done does not fire, but full goes high immediately.
- Overshift: shifting beyond eff_len continues to shift data (old bits drop out); bit_cnt saturates at WIDTH.
- Simultaneous load and enable: load wins; the serial_in bit is discarded and bit_cnt = 0.
- Reset mid-field: all state returns to reset values on that edge; no done pulse is issued for the partial field.
- Latency:
  - par_out, serial_out and bit_cnt reflect a shift one cycle after the enable edge.
  - full is valid in the same cycle as bit_cnt.
  - done aligns with full's rising edge.
- No X propagation: all registers are reset, and par_in is only sampled on load.

Test Plan:
1. Reset/priority: assert reset together with load = 1, par_in = 8'hA5 -> next cycle par_out = 0, bit_cnt = 0, full = 0, done = 0. Then clear + load in the same cycle -> par_out = 0.
2. MSB-first assembly (WIDTH = 8, LSB_FIRST = 0, len = 0): shift serial bits 1,0,1,0,0,1,0,1 -> par_out = 8'hA5, bit_cnt = 8. done is high for exactly one cycle after the 8th shift; full stays 1. A 9th shift of 1 -> par_out = 8'h4B, bit_cnt = 8, no done.
3. Transmit serialisation (LSB_FIRST = 1): load par_in = 8'h96 -> serial_out sequence over 8 enables = 0,1,1,0,1,0,0,1. bit_cnt counts 0..8.
4. Short field (len = 4, DLC capture): shift bits 0,1,0,1 -> par_out[3:0] = 4'h5, done pulses after the 4th shift, bit_cnt = 4. Changing len to 3 afterward -> full stays 1, no new done.
5. Collision: load with par_in = 8'h3C together with enable and serial_in = 1 -> par_out = 8'h3C, bit_cnt = 0, done = 0.
6. Reset mid-field: after 5 of 8 shifts assert reset for 1 cycle -> all outputs 0. Then 8 shifts of serial_in = 1 -> par_out = 8'hFF with a single done pulse.
